// File: rtl/itype_seq_ctrl.sv
// Multi-cycle I-type sequencer: IDLE -> READ -> EXEC -> COMMIT.
// Ports: instr handshake, RF read/write, ALU operands/result, pc, busy, exc pulses.
module itype_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        busy,
  output logic        exc_ovf,
  output logic        exc_ill
);

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE, READ, EXEC, COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [15:0] imm_q, imm_d;
  logic        ill_q, ill_d;
  logic [31:0] rsd_q, rsd_d;
  logic [31:0] rtd_q, rtd_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic [31:0] pc_q, pc_d;

  logic        is_lui, is_logic, is_br;
  logic        is_wr, taken;
  logic [31:0] imm_ext;
  logic [5:0]  in_op;
  logic        in_legal;

  assign in_op = instr[31:26];

  always_comb begin
    in_legal = 1'b0;
    unique case (in_op)
      OP_BEQ, OP_BNE, OP_ADDI,
      OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LUI:
        in_legal = 1'b1;
      default: in_legal = 1'b0;
    endcase
  end

  always_comb begin
    is_lui   = (op_q == OP_LUI);
    is_logic = (op_q == OP_ANDI) ||
               (op_q == OP_ORI);
    is_br    = (op_q == OP_BEQ) ||
               (op_q == OP_BNE);
    is_wr    = !is_br && !ill_q;
    taken    = ((op_q == OP_BEQ) && zero_q) ||
               ((op_q == OP_BNE) && !zero_q);
    imm_ext  = {{16{imm_q[15]}}, imm_q};
    unique case (1'b1)
      is_lui:   imm_ext = {imm_q, 16'h0000};
      is_logic: imm_ext = {16'h0000, imm_q};
      default:  imm_ext = {{16{imm_q[15]}}, imm_q};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_d    = imm_q;
    ill_d    = ill_q;
    rsd_d    = rsd_q;
    rtd_d    = rtd_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    pc_d     = pc_q;
    alu_op   = 6'b000000;
    alu_rs   = 32'h0;
    alu_rt   = 32'h0;
    alu_imm  = 32'h0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    exc_ovf  = 1'b0;
    exc_ill  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d  = in_op;
          rs_d  = instr[25:21];
          rt_d  = instr[20:16];
          imm_d = instr[15:0];
          ill_d = !in_legal;
          // Illegal opcodes jump straight to the retire cycle.
          state_d = in_legal ? READ : COMMIT;
        end
      end
      READ: begin
        rsd_d   = rs_data;
        rtd_d   = rt_data;
        state_d = EXEC;
      end
      EXEC: begin
        alu_op  = op_q;
        alu_rs  = rsd_q;
        alu_rt  = rtd_q;
        alu_imm = imm_ext;
        res_d   = alu_result;
        zero_d  = alu_zero;
        ovf_d   = alu_ovf;
        state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        pc_d    = pc_q + 32'd4;
        if (ill_q) begin
          exc_ill = 1'b1;
        end else begin
          exc_ovf = (op_q == OP_ADDI) && ovf_q;
          rf_we   = is_wr && (rt_q != 5'd0) &&
                    !exc_ovf;
          if (rf_we) begin
            rf_waddr = rt_q;
            rf_wdata = res_q;
          end
          if (taken)
            pc_d = pc_q + 32'd4 +
                   {{14{imm_q[15]}}, imm_q, 2'b00};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 6'd0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      imm_q   <= 16'd0;
      ill_q   <= 1'b0;
      rsd_q   <= 32'h0;
      rtd_q   <= 32'h0;
      res_q   <= 32'h0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      ill_q   <= ill_d;
      rsd_q   <= rsd_d;
      rtd_q   <= rtd_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rs_addr     = rs_q;
  assign rt_addr     = rt_q;
  assign pc          = pc_q;

endmodule
